// File: rtl/merge_reduce_router_if.sv
`default_nettype none
// ============================================================================
// merge_reduce_router_if : per-port flit bus (data/valid/ready) for the router
// Revision: 1.0
// ============================================================================
interface merge_reduce_router_if #(
  parameter int NP = 5,
  parameter int DW = 32
);
  logic [DW-1:0] data [NP];
  logic [NP-1:0] valid;
  logic [NP-1:0] ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/merge_reduce_router.sv
`default_nettype none
// ============================================================================
// merge_reduce_router : joins one flit per masked input, reduces the payloads
// (wrap sum / saturating sum / signed max), multicasts in lockstep.
// Revision: 1.0
// ============================================================================
`ifndef DW
`define DW 32
`endif
`ifndef MERGE_ROUTER_BUFFER_DEPTH_LOG
`define MERGE_ROUTER_BUFFER_DEPTH_LOG 2
`endif

module merge_reduce_router #(
  parameter int              NP         = 5,
  parameter int              DW         = `DW,
  parameter int              DEPTH_LOG  = `MERGE_ROUTER_BUFFER_DEPTH_LOG,
  parameter logic [NP-1:0]   INPUT_MASK = '0,
  parameter logic [NP-1:0]   OUTPUT_SEL = '0,
  parameter int              MODE       = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  merge_reduce_router_if.slave    in_if,
  merge_reduce_router_if.master   out_if,
  output logic                    err_o,
  output logic [15:0]             flit_cnt_o
);

  localparam int PW    = DW - 2;
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int SW    = PW + $clog2(NP);
  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(PW-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic [NP-1:0] ready_w;
  logic [NP-1:0] nonempty;
  logic [DW-1:0] head [NP];
  logic          load;

  // Per-input FWFT buffers; unmasked ports never accept and never block the join
  for (genvar i = 0; i < NP; i++) begin : g_in
    if (INPUT_MASK[i]) begin : g_buf
      logic [DW-1:0]        mem_q [DEPTH];
      logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [DEPTH_LOG:0]   occ_q, occ_d;
      logic                 push;

      assign ready_w[i]  = (occ_q != (DEPTH_LOG+1)'(DEPTH)) & rstn;
      assign nonempty[i] = (occ_q != '0);
      assign head[i]     = mem_q[rd_ptr_q];

      always_comb begin
        push     = in_if.valid[i] & ready_w[i];
        wr_ptr_d = wr_ptr_q + DEPTH_LOG'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG'(load);
        occ_d    = occ_q + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(load);
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.data[i];
      end
    end else begin : g_none
      assign ready_w[i]  = 1'b0;
      assign nonempty[i] = 1'b0;
      assign head[i]     = '0;
    end
  end

  assign in_if.ready = ready_w;

  logic signed [SW-1:0] sum_w;
  logic signed [PW-1:0] pay_w, max_w;
  logic [PW-1:0]        res_w;
  logic [1:0]           type_w;
  logic                 mismatch_w, first_w;

  always_comb begin
    sum_w      = '0;
    pay_w      = '0;
    max_w      = '0;
    type_w     = '0;
    mismatch_w = 1'b0;
    first_w    = 1'b1;
    for (int i = 0; i < NP; i++) begin
      if (INPUT_MASK[i]) begin
        pay_w = head[i][PW-1:0];
        sum_w = sum_w + SW'(pay_w);
        if (first_w || (pay_w > max_w)) max_w = pay_w;
        if (first_w) type_w = head[i][DW-1:PW];
        else if (head[i][DW-1:PW] != type_w) mismatch_w = 1'b1;
        first_w = 1'b0;
      end
    end
    res_w = sum_w[PW-1:0];
    case (MODE)
      0: res_w = sum_w[PW-1:0];
      1: begin
        if (sum_w > SAT_MAX)      res_w = SAT_MAX[PW-1:0];
        else if (sum_w < SAT_MIN) res_w = SAT_MIN[PW-1:0];
        else                      res_w = sum_w[PW-1:0];
      end
      default: res_w = max_w;
    endcase
  end

  logic          vq_q, vq_d;
  logic [DW-1:0] dq_q, dq_d;
  logic          err_q, err_d;
  logic [15:0]   flit_cnt_q, flit_cnt_d;
  logic          all_ready, join_valid;

  // The output flit retires only when every selected destination is ready together
  always_comb begin
    all_ready  = &(out_if.ready | ~OUTPUT_SEL);
    join_valid = &(nonempty | ~INPUT_MASK);
    load       = join_valid & (~vq_q | all_ready);
    vq_d       = vq_q;
    if (load)           vq_d = 1'b1;
    else if (all_ready) vq_d = 1'b0;
    dq_d       = load ? {type_w, res_w} : dq_q;
    err_d      = err_q | (load & mismatch_w);
    flit_cnt_d = flit_cnt_q + 16'(load);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vq_q       <= 1'b0;
      dq_q       <= '0;
      err_q      <= 1'b0;
      flit_cnt_q <= '0;
    end else begin
      vq_q       <= vq_d;
      dq_q       <= dq_d;
      err_q      <= err_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  for (genvar j = 0; j < NP; j++) begin : g_out
    assign out_if.valid[j] = OUTPUT_SEL[j] & vq_q;
    assign out_if.data[j]  = OUTPUT_SEL[j] ? dq_q : '0;
  end

  assign err_o      = err_q;
  assign flit_cnt_o = flit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_merge_reduce_router.sv
`default_nettype none
// ============================================================================
// tb_merge_reduce_router : four router configurations driven with directed
// vectors; a per-instance monitor pops a scoreboard on every retired flit.
// Revision: 1.0
// ============================================================================
module tb_merge_reduce_router;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  // instance k: k0 wrap-sum, k1 saturating, k2 max/multicast, k3 two-input depth test
  localparam logic [19:0] MASKS = {5'b00011, 5'b01110, 5'b11110, 5'b11110};
  localparam logic [19:0] SELS  = {5'b00001, 5'b00011, 5'b10000, 5'b10000};
  localparam logic [7:0]  MODES = {2'd0, 2'd2, 2'd1, 2'd0};

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data  [4][5];
  logic [31:0] out_data [4][5];
  logic [4:0]  in_valid [4];
  logic [4:0]  in_ready [4];
  logic [4:0]  out_valid[4];
  logic [4:0]  out_ready[4];
  logic        err      [4];
  logic [15:0] cnt      [4];

  logic [31:0] exp_q [4][$];
  int          pop_cyc3[$];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam logic [4:0] SEL_K   = SELS[k*5 +: 5];
    localparam int         FIRST_K = (k >= 2) ? 0 : 4;
    logic [31:0] e_m;
    logic        ok_m;

    merge_reduce_router_if #(.NP(5), .DW(32)) in_if ();
    merge_reduce_router_if #(.NP(5), .DW(32)) out_if ();

    for (genvar i = 0; i < 5; i++) begin : g_p
      assign in_if.data[i]  = in_data[k][i];
      assign out_data[k][i] = out_if.data[i];
    end
    assign in_if.valid  = in_valid[k];
    assign in_ready[k]  = in_if.ready;
    assign out_valid[k] = out_if.valid;
    assign out_if.ready = out_ready[k];

    merge_reduce_router #(
      .NP(5), .DW(32), .DEPTH_LOG(2),
      .INPUT_MASK(MASKS[k*5 +: 5]), .OUTPUT_SEL(SEL_K), .MODE(int'(MODES[k*2 +: 2]))
    ) u_dut (
      .clk(clk), .rstn(rstn), .in_if(in_if), .out_if(out_if),
      .err_o(err[k]), .flit_cnt_o(cnt[k])
    );

    always @(negedge clk) begin
      if (rstn && out_valid[k][FIRST_K] && ((out_ready[k] | ~SEL_K) == 5'h1F)) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL dut%0d_unexpected_flit got %h expected none", k, out_data[k][FIRST_K]);
        end else begin
          e_m  = exp_q[k].pop_front();
          ok_m = 1'b1;
          for (int j = 0; j < 5; j++) begin
            if (SEL_K[j]) ok_m &= out_valid[k][j] && (out_data[k][j] == e_m);
            else          ok_m &= !out_valid[k][j] && (out_data[k][j] == 32'h0);
          end
          if (!ok_m) begin
            errors++;
            $display("FAIL dut%0d_flit got data %h valid %b expected %h on sel %b",
                     k, out_data[k][FIRST_K], out_valid[k], e_m, SEL_K);
          end
        end
        if (k == 3) pop_cyc3.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input int p);
    return {t, 30'(p)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic send(input int k, input logic [4:0] m,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] d3, input logic [31:0] d4);
    int w;
    @(negedge clk);
    in_data[k][0] = d0; in_data[k][1] = d1; in_data[k][2] = d2;
    in_data[k][3] = d3; in_data[k][4] = d4;
    in_valid[k] = m;
    w = 0;
    while (((in_ready[k] & m) != m) && (w < 50)) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: ready %b required %b", k, in_ready[k], m);
    end
    @(posedge clk);
    #1 in_valid[k] = 5'b0;
  endtask

  task automatic drain(input int k);
    int w;
    w = 0;
    while ((exp_q[k].size() != 0) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("drain_dut%0d", k), 64'(exp_q[k].size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic r;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) in_data[k][i] = 32'h0;
      in_valid[k]  = 5'h1F;
      out_ready[k] = 5'h1F;
    end

    // Reset with valid_i active
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", in_ready[0], 5'b0);
    chk("rst_valid0", out_valid[0], 5'b0);
    chk("rst_data0",  out_data[0][4], 32'h0);
    chk("rst_cnt0",   cnt[0], 16'h0);
    chk("rst_err0",   err[0], 1'b0);
    for (int k = 0; k < 4; k++) in_valid[k] = 5'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_ready0", in_ready[0], 5'b11110);
    chk("rel_ready3", in_ready[3], 5'b00011);

    // MODE0 sum with latency check
    exp_q[0].push_back(mk(BODY, -4));
    send(0, 5'b11110, 0, mk(BODY, 1), mk(BODY, 2), mk(BODY, 3), mk(BODY, -10));
    chk("lat_edge_t", out_valid[0][4], 1'b0);
    @(posedge clk);
    #1;
    chk("lat_edge_t1", out_valid[0][4], 1'b1);
    chk("sum_data", out_data[0][4], 32'h7FFFFFFC);

    exp_q[0].push_back(mk(BODY, 32'h3FFFFFFC));
    send(0, 5'b11110, 0, mk(BODY, 32'h1FFFFFFF), mk(BODY, 32'h1FFFFFFF),
         mk(BODY, 32'h1FFFFFFF), mk(BODY, 32'h1FFFFFFF));
    exp_q[0].push_back(mk(BODY, 0));
    send(0, 5'b11110, 0, mk(BODY, 32'h20000000), mk(BODY, 32'h20000000),
         mk(BODY, 32'h20000000), mk(BODY, 32'h20000000));
    exp_q[0].push_back(mk(BODY, 77));
    send(0, 5'b11110, 0, mk(BODY, 100), mk(BODY, -30), mk(BODY, 7), mk(BODY, 0));
    drain(0);

    // MODE1 saturating
    exp_q[1].push_back(mk(BODY, 32'h1FFFFFFF));
    send(1, 5'b11110, 0, mk(BODY, 32'h1FFFFFFF), mk(BODY, 32'h1FFFFFFF),
         mk(BODY, 32'h1FFFFFFF), mk(BODY, 32'h1FFFFFFF));
    exp_q[1].push_back(mk(BODY, 32'h20000000));
    send(1, 5'b11110, 0, mk(BODY, 32'h20000000), mk(BODY, 32'h20000000),
         mk(BODY, 32'h20000000), mk(BODY, 32'h20000000));
    exp_q[1].push_back(mk(BODY, 26));
    send(1, 5'b11110, 0, mk(BODY, 5), mk(BODY, 6), mk(BODY, 7), mk(BODY, 8));
    exp_q[1].push_back(mk(BODY, 32'h1FFFFFFF));
    send(1, 5'b11110, 0, mk(BODY, 32'h1FFFFFFF), mk(BODY, 1), mk(BODY, 0), mk(BODY, 0));
    exp_q[1].push_back(mk(BODY, 32'h20000000));
    send(1, 5'b11110, 0, mk(BODY, 32'h20000000), mk(BODY, -1), mk(BODY, 0), mk(BODY, 0));
    drain(1);

    // MODE2 with multicast stall on output 1
    @(posedge clk);
    #1 out_ready[2] = 5'b11101;
    exp_q[2].push_back(mk(BODY, 7));
    send(2, 5'b01110, 0, mk(BODY, -5), mk(BODY, 7), mk(BODY, 3), 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", out_valid[2][1:0], 2'b11);
      chk("stall_data0", out_data[2][0], 32'h40000007);
      chk("stall_data1", out_data[2][1], 32'h40000007);
      chk("stall_cnt", cnt[2], 16'd1);
    end
    @(posedge clk);
    #1 out_ready[2] = 5'h1F;
    @(posedge clk);
    #1;
    chk("retire_valid", out_valid[2][1:0], 2'b00);
    chk("retire_cnt", cnt[2], 16'd1);
    chk("retire_q", 64'(exp_q[2].size()), 64'd0);
    exp_q[2].push_back(mk(BODY, -3));
    send(2, 5'b01110, 0, mk(BODY, -8), mk(BODY, -3), mk(BODY, -100), 0);
    exp_q[2].push_back(mk(BODY, 32'h1FFFFFFF));
    send(2, 5'b01110, 0, mk(BODY, 32'h1FFFFFFF), mk(BODY, 32'h20000000), mk(BODY, 0), 0);
    drain(2);

    // Buffer full: input 0 streams while input 1 is silent
    acc = 0;
    n   = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_data[3][0] = mk(BODY, 10 * (n + 1));
      in_valid[3]   = 5'b00001;
      r = in_ready[3][0];
      @(posedge clk);
      if (r) begin
        acc++;
        n++;
      end
    end
    @(negedge clk);
    in_valid[3] = 5'b0;
    chk("full_accepted", 64'(acc), 64'd4);
    chk("full_ready0", in_ready[3][0], 1'b0);
    chk("full_ready1", in_ready[3][1], 1'b1);
    for (int i = 1; i <= 4; i++) begin
      exp_q[3].push_back(mk(BODY, 11 * i));
      send(3, 5'b00010, 0, mk(BODY, i), 0, 0, 0);
    end
    drain(3);
    chk("pop_count3", 64'(pop_cyc3.size()), 64'd4);
    if (pop_cyc3.size() == 4) chk("pop_rate3", 64'(pop_cyc3[3] - pop_cyc3[0]), 64'd3);
    chk("drained_ready0", in_ready[3][0], 1'b1);

    // Type mismatch then clean traffic
    exp_q[0].push_back(mk(HEAD, 4));
    send(0, 5'b11110, 0, mk(HEAD, 1), mk(BODY, 1), mk(BODY, 1), mk(BODY, 1));
    chk("err_before_load", err[0], 1'b0);
    @(posedge clk);
    #1;
    chk("err_set", err[0], 1'b1);
    for (int i = 1; i <= 10; i++) begin
      exp_q[0].push_back(mk(HEAD, 4 * i));
      send(0, 5'b11110, 0, mk(HEAD, i), mk(HEAD, i), mk(HEAD, i), mk(HEAD, i));
    end
    drain(0);
    chk("err_sticky", err[0], 1'b1);
    chk("flit_cnt0", cnt[0], 16'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
